// File: rtl/fb_draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fb_draw_scheduler
//  Purpose  : Write-side controller for the dual-clock frame buffer. Shares
//             one write port between NUM_REQ rectangle requesters using
//             round-robin arbitration. Each granted rectangle is expanded
//             into one pixel write per cycle, with off-screen pixels masked.
//  Options  : FB_SCHED_CLEAR_EN - adds a full-screen clear pass, started by
//             frame_start, that runs between rectangles.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_draw_scheduler #(
  parameter int          NUM_REQ     = 3,
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          XW          = 10,
  parameter int          YW          = 9,
  parameter int          AW          = 19,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*XW-1:0] rect_x,
  input  logic [NUM_REQ*YW-1:0] rect_y,
  input  logic [NUM_REQ*XW-1:0] rect_w,
  input  logic [NUM_REQ*YW-1:0] rect_h,
  input  logic [NUM_REQ*24-1:0] rect_color,
  output logic [NUM_REQ-1:0]    ack,
  output logic [AW-1:0]         write_addr,
  output logic [23:0]           write_data,
  output logic                  write_en,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int                 c_IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [XW-1:0]      c_X1   = XW'(1);
  localparam logic [YW-1:0]      c_Y1   = YW'(1);
  localparam logic [NUM_REQ-1:0] c_ACK1 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_GRANT = 2'd2,
    S_FILL  = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic [c_IW-1:0]     r_ptr, r_win, w_win;
  logic [XW-1:0]       r_x, r_w, r_col, w_sel_x, w_sel_w;
  logic [YW-1:0]       r_y, r_h, r_row, w_sel_y, w_sel_h;
  logic [23:0]         r_color, w_sel_color;
  logic [NUM_REQ-1:0]  r_ack;
  logic [AW-1:0]       r_addr;
  logic [23:0]         r_data;
  logic                r_we;
  logic [XW:0]         w_px;
  logic [YW:0]         w_py;
  logic                w_in, w_col_last, w_fill_last;
  logic                w_clr_go, w_clr_last;

  // Round-robin search: the set bit nearest after r_ptr (mod NUM_REQ) wins;
  // descending k lets the nearest candidate overwrite farther ones.
  always_comb begin
    w_win = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_ptr) + k) % NUM_REQ])
        w_win = c_IW'((int'(r_ptr) + k) % NUM_REQ);
    end
  end

  // Select the granted requester's rectangle fields from the packed buses.
  always_comb begin
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_w     = '0;
    w_sel_h     = '0;
    w_sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_win == c_IW'(i)) begin
        w_sel_x     = rect_x[i*XW +: XW];
        w_sel_y     = rect_y[i*YW +: YW];
        w_sel_w     = rect_w[i*XW +: XW];
        w_sel_h     = rect_h[i*YW +: YW];
        w_sel_color = rect_color[i*24 +: 24];
      end
    end
  end

  // Pixel coordinates carry one extra bit so right/bottom overhang never wraps.
  assign w_px        = {1'b0, r_x} + {1'b0, r_col};
  assign w_py        = {1'b0, r_y} + {1'b0, r_row};
  assign w_in        = (32'(w_px) < 32'(H_RES)) && (32'(w_py) < 32'(V_RES));
  assign w_col_last  = (r_col == r_w - c_X1);
  assign w_fill_last = w_col_last && (r_row == r_h - c_Y1);

`ifdef FB_SCHED_CLEAR_EN
  localparam logic [AW-1:0] c_CLR_LAST = AW'(H_RES * V_RES - 1);
  localparam logic [AW-1:0] c_A1       = AW'(1);

  logic [AW-1:0] r_clr_addr;
  logic          r_clear_pending, r_clr_fin, r_clear_done;

  // A pulse arriving in IDLE starts the clear at once, ahead of any request.
  assign w_clr_go   = r_clear_pending | frame_start;
  assign w_clr_last = (r_clr_addr == c_CLR_LAST);
  assign clear_done = r_clear_done;

  // Clear bookkeeping: pending flag, address counter and the done pulse,
  // which trails the last clear write by one cycle.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      r_clear_pending <= 1'b0;
      r_clr_addr      <= '0;
      r_clr_fin       <= 1'b0;
      r_clear_done    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_clr_go)
        r_clear_pending <= 1'b0;
      else if (frame_start && r_state != S_CLEAR)
        r_clear_pending <= 1'b1;
      if (r_state == S_CLEAR)
        r_clr_addr <= r_clr_addr + c_A1;
      else
        r_clr_addr <= '0;
      r_clr_fin    <= (r_state == S_CLEAR) && w_clr_last;
      r_clear_done <= r_clr_fin;
    end
  end
`else
  logic w_unused;

  assign w_clr_go   = 1'b0;
  assign w_clr_last = 1'b0;
  assign clear_done = 1'b0;
  assign w_unused   = ^{frame_start, CLEAR_COLOR};
`endif

  // State register.
  always_ff @(posedge write_clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; a clear only starts from IDLE, so rectangles finish.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_clr_go)
          w_next = S_CLEAR;
        else if (|req)
          w_next = S_GRANT;
      end
      S_GRANT: begin
        if (w_sel_w == '0 || w_sel_h == '0)
          w_next = S_IDLE;
        else
          w_next = S_FILL;
      end
      S_FILL:  if (w_fill_last) w_next = S_IDLE;
      S_CLEAR: if (w_clr_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: winner capture, field latch, pixel scan and registered port.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      r_ptr   <= c_IW'(NUM_REQ - 1);
      r_win   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_ack   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_ack <= '0;
      r_we  <= 1'b0;
      case (r_state)
        S_IDLE: r_win <= w_win;
        S_GRANT: begin
          r_x     <= w_sel_x;
          r_y     <= w_sel_y;
          r_w     <= w_sel_w;
          r_h     <= w_sel_h;
          r_color <= w_sel_color;
          r_col   <= '0;
          r_row   <= '0;
          r_ptr   <= r_win;
          r_ack   <= c_ACK1 << r_win;
        end
        S_FILL: begin
          // Clipped pixels still take their cycle; address/data hold.
          if (w_in) begin
            r_addr <= AW'(w_py) * AW'(H_RES) + AW'(w_px);
            r_data <= r_color;
            r_we   <= 1'b1;
          end
          if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + c_Y1;
          end else begin
            r_col <= r_col + c_X1;
          end
        end
        S_CLEAR: begin
`ifdef FB_SCHED_CLEAR_EN
          r_addr <= r_clr_addr;
          r_data <= CLEAR_COLOR;
          r_we   <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ack        = r_ack;
  assign write_addr = r_addr;
  assign write_data = r_data;
  assign write_en   = r_we;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
